// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access kinds, scanner verdict causes and scanner states.
// Latency: n/a (types only).
// Backpressure: n/a.
package rv_iopmp_pkg;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2,
    ACC_EXEC  = 2'd3
  } access_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_NO_MATCH = 2'd1,
    ERR_PERM     = 2'd2,
    ERR_PARTIAL  = 2'd3
  } scan_err_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } scan_state_t;

endpackage

// File: rtl/rv_iopmp_entry_scanner.sv
// Walks a requester's IOPMP entry range one entry per cycle and resolves an allow/deny verdict.
// Latency: k scanned entries -> verdict k+1 cycles after accept; accept-time decisions -> 1 cycle.
// Backpressure: one transaction in flight; verdict held until rsp_ready_i, req_ready_o only in IDLE.
module rv_iopmp_entry_scanner
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned NUM_ENTRY  = 32,
  parameter int unsigned PRIO_ENTRY = 16,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  localparam int unsigned IDX_W = $clog2(NUM_ENTRY) + 1,
  localparam int unsigned NB_W  = $clog2(DATA_WIDTH / 8) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [NB_W-1:0]       num_bytes_i,
  input  access_t               access_i,
  input  logic [IDX_W-1:0]      entry_start_i,
  input  logic [IDX_W-1:0]      entry_end_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH-1:0] final_addr_o,
  output logic [NB_W-1:0]       num_bytes_o,
  output access_t               access_o,
  output logic [IDX_W-1:0]      entry_idx_o,
  input  logic                  entry_match_i,
  input  logic                  entry_partial_i,
  input  logic                  entry_allow_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_allow_o,
  output scan_err_t             rsp_err_o,
  output logic [IDX_W-1:0]      rsp_entry_idx_o,
  output logic                  busy_o
);

  scan_state_t state_q;

  // Latched exclusive end of the range, already clamped to the table size.
  logic [IDX_W-1:0] end_q;

  // First non-priority failure seen during the scan; reported if nothing grants access.
  logic             rec_vld_q;
  scan_err_t        rec_err_q;
  logic [IDX_W-1:0] rec_idx_q;

  // Accept-time helpers.
  logic [IDX_W-1:0]    end_clamped;
  logic [NB_W-1:0]     nb_eff;
  logic [ADDR_WIDTH:0] final_ext;

  assign end_clamped = (entry_end_i > IDX_W'(NUM_ENTRY)) ? IDX_W'(NUM_ENTRY) : entry_end_i;
  assign nb_eff      = (num_bytes_i == '0) ? NB_W'(1) : num_bytes_i;
  // One extra bit so that a window running past the top of the address space is visible as a carry.
  assign final_ext   = {1'b0, addr_i}
                     + {{(ADDR_WIDTH + 1 - NB_W){1'b0}}, nb_eff}
                     - {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Per-entry helpers for the scan.
  logic      is_prio;
  logic      last_entry;
  logic      fail_now;
  scan_err_t cause_now;

  assign is_prio    = (entry_idx_o < IDX_W'(PRIO_ENTRY));
  assign last_entry = (entry_idx_o == (end_q - IDX_W'(1)));
  // A non-priority entry that would deny; match takes precedence over partial.
  assign fail_now   = !is_prio &&
                      ((entry_match_i && !entry_allow_i) || (!entry_match_i && entry_partial_i));
  assign cause_now  = entry_match_i ? ERR_PERM : ERR_PARTIAL;

  logic             scan_done;
  logic             scan_allow;
  scan_err_t        scan_err;
  logic [IDX_W-1:0] scan_idx;

  // Decide whether the entry under examination ends the scan, and with which verdict.
  always_comb begin
    scan_done  = 1'b0;
    scan_allow = 1'b0;
    scan_err   = ERR_NONE;
    scan_idx   = entry_idx_o;
    if (is_prio && entry_match_i) begin
      scan_done  = 1'b1;
      scan_allow = entry_allow_i;
      scan_err   = entry_allow_i ? ERR_NONE : ERR_PERM;
    end else if (is_prio && entry_partial_i) begin
      scan_done = 1'b1;
      scan_err  = ERR_PARTIAL;
    end else if (!is_prio && entry_match_i && entry_allow_i) begin
      scan_done  = 1'b1;
      scan_allow = 1'b1;
    end else if (last_entry) begin
      scan_done = 1'b1;
      if (rec_vld_q) begin
        scan_err = rec_err_q;
        scan_idx = rec_idx_q;
      end else if (fail_now) begin
        scan_err = cause_now;
      end else begin
        scan_err = ERR_NO_MATCH;
        scan_idx = '0;
      end
    end
  end

  // Control FSM with registered handshake, analyzer-side and verdict outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      req_ready_o     <= 1'b1;
      busy_o          <= 1'b0;
      addr_o          <= '0;
      final_addr_o    <= '0;
      num_bytes_o     <= '0;
      access_o        <= ACC_NONE;
      entry_idx_o     <= '0;
      end_q           <= '0;
      rec_vld_q       <= 1'b0;
      rec_err_q       <= ERR_NONE;
      rec_idx_q       <= '0;
      rsp_valid_o     <= 1'b0;
      rsp_allow_o     <= 1'b0;
      rsp_err_o       <= ERR_NONE;
      rsp_entry_idx_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_o       <= addr_i;
            final_addr_o <= final_ext[ADDR_WIDTH-1:0];
            num_bytes_o  <= num_bytes_i;
            access_o     <= access_i;
            end_q        <= end_clamped;
            entry_idx_o  <= entry_start_i;
            rec_vld_q    <= 1'b0;
            req_ready_o  <= 1'b0;
            busy_o       <= 1'b1;
            if (!enable_i || final_ext[ADDR_WIDTH] || (entry_start_i >= end_clamped)) begin
              state_q         <= RESP;
              rsp_valid_o     <= 1'b1;
              rsp_allow_o     <= !enable_i;
              rsp_entry_idx_o <= '0;
              if (!enable_i) begin
                rsp_err_o <= ERR_NONE;
              end else if (final_ext[ADDR_WIDTH]) begin
                rsp_err_o <= ERR_PARTIAL;
              end else begin
                rsp_err_o <= ERR_NO_MATCH;
              end
            end else begin
              state_q <= SCAN;
            end
          end
        end
        SCAN: begin
          if (scan_done) begin
            state_q         <= RESP;
            rsp_valid_o     <= 1'b1;
            rsp_allow_o     <= scan_allow;
            rsp_err_o       <= scan_err;
            rsp_entry_idx_o <= scan_idx;
          end else begin
            entry_idx_o <= entry_idx_o + IDX_W'(1);
            if (fail_now && !rec_vld_q) begin
              rec_vld_q <= 1'b1;
              rec_err_q <= cause_now;
              rec_idx_q <= entry_idx_o;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
